// File: rtl/decode_issue_pkg.sv
// Shared types for the decode/issue stage: ALU op codes, instruction layout,
// register-file sizing and the input-buffer state encoding.
package definitions;

    typedef enum logic [1:0] {
        OP_OR  = 2'd0,
        OP_AND = 2'd1,
        OP_ADD = 2'd2,
        OP_SUB = 2'd3
    } op_code;

    localparam int NUM_REGS = 8;
    localparam int REG_AW   = $clog2(NUM_REGS);

    typedef logic [REG_AW-1:0] reg_addr_t;

    typedef struct packed {
        op_code     op;       // [31:30]
        reg_addr_t  rd;       // [29:27]
        reg_addr_t  ra;       // [26:24]
        reg_addr_t  rb;       // [23:21]
        logic       use_imm;  // [20]
        logic [3:0] ign;      // [19:16] carried but never interpreted
        logic [15:0] imm;     // [15:0]
    } instr_t;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } dec_state_e;

    // Source operand with same-cycle writeback forwarding; r0 is never forwarded.
    function automatic logic [31:0] bypass(reg_addr_t addr, logic [31:0] rf_data,
                                           logic wb_en, reg_addr_t wb_addr,
                                           logic [31:0] wb_data);
        if (wb_en && (wb_addr == addr) && (addr != '0)) return wb_data;
        return rf_data;
    endfunction

endpackage

// File: rtl/decode_issue_if.sv
// Instruction-in, writeback-in and issue-out channels of the decode/issue stage.
interface decode_issue_if;
    import definitions::*;

    logic        instr_valid_i;
    logic [31:0] instr_i;
    logic        instr_ready_o;

    logic        wb_en_i;
    reg_addr_t   wb_addr_i;
    logic [31:0] wb_data_i;

    logic        ex_valid_o;
    logic        ex_ready_i;
    logic [31:0] rs_o;
    logic [31:0] rt_o;
    op_code      op_o;
    reg_addr_t   rd_o;

    modport slave (
        input  instr_valid_i, instr_i, wb_en_i, wb_addr_i, wb_data_i, ex_ready_i,
        output instr_ready_o, ex_valid_o, rs_o, rt_o, op_o, rd_o
    );

    modport master (
        output instr_valid_i, instr_i, wb_en_i, wb_addr_i, wb_data_i, ex_ready_i,
        input  instr_ready_o, ex_valid_o, rs_o, rt_o, op_o, rd_o
    );

endinterface

// File: rtl/decode_issue_regfile_8x32.sv
// 8x32 register file: two combinational read ports, one clocked write port,
// r0 hardwired to zero.
module regfile_8x32
    import definitions::*;
(
    input  logic        clk,
    input  logic        reset,
    input  reg_addr_t   raddr_a,
    input  reg_addr_t   raddr_b,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    input  logic        we,
    input  reg_addr_t   waddr,
    input  logic [31:0] wdata
);

    logic [31:0] regs_q [NUM_REGS];
    logic [31:0] regs_d [NUM_REGS];

    always_comb begin
        // NOTE: default every always_comb output first so no path infers a latch.
        regs_d = regs_q;
        if (we && (waddr != '0)) regs_d[waddr] = wdata;
    end

    // NOTE: this array is small and must read zero after reset, so it is reset
    // as flops; a large RAM would not be.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignment only.
            regs_q <= regs_d;
        end
    end

    assign rdata_a = (raddr_a == '0) ? '0 : regs_q[raddr_a];
    assign rdata_b = (raddr_b == '0) ? '0 : regs_q[raddr_b];

endmodule

// File: rtl/decode_issue.sv
// Decode/issue stage: one-entry instruction buffer, scoreboard hazard check,
// operand read with writeback bypass and a registered issue slot to the ALU.
module decode_issue
    import definitions::*;
(
    input logic           clk,
    input logic           reset,
    decode_issue_if.slave bus
);

    dec_state_e          state_q, state_d;
    instr_t              buf_q, buf_d;
    logic [NUM_REGS-1:0] pend_q, pend_d;

    logic                ex_valid_q, ex_valid_d;
    logic [31:0]         rs_q, rs_d;
    logic [31:0]         rt_q, rt_d;
    op_code              op_q, op_d;
    reg_addr_t           rd_q, rd_d;

    logic [31:0]         rf_a, rf_b;
    logic [31:0]         opnd_a, opnd_b;
    logic [NUM_REGS-1:0] wb_mask;
    logic [NUM_REGS-1:0] eff_pend;
    logic                hazard;
    logic                issue;
    logic                handshake;
    logic [3:0]          unused_ign;

    regfile_8x32 u_regfile (
        .clk     (clk),
        .reset   (reset),
        .raddr_a (buf_q.ra),
        .raddr_b (buf_q.rb),
        .rdata_a (rf_a),
        .rdata_b (rf_b),
        .we      (bus.wb_en_i),
        .waddr   (bus.wb_addr_i),
        .wdata   (bus.wb_data_i)
    );

    // A register written back this cycle no longer blocks its readers.
    always_comb begin
        wb_mask = '0;
        if (bus.wb_en_i) wb_mask[bus.wb_addr_i] = 1'b1;
    end

    assign eff_pend  = pend_q & ~wb_mask;
    assign hazard    = eff_pend[buf_q.ra]
                     | (~buf_q.use_imm & eff_pend[buf_q.rb])
                     | eff_pend[buf_q.rd];
    assign issue     = (state_q == FULL) && !hazard && (!ex_valid_q || bus.ex_ready_i);
    assign handshake = bus.instr_valid_i && bus.instr_ready_o;
    assign unused_ign = buf_q.ign;

    assign opnd_a = bypass(buf_q.ra, rf_a, bus.wb_en_i, bus.wb_addr_i, bus.wb_data_i);
    assign opnd_b = buf_q.use_imm ? {16'h0000, buf_q.imm}
                  : bypass(buf_q.rb, rf_b, bus.wb_en_i, bus.wb_addr_i, bus.wb_data_i);

    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        ex_valid_d = ex_valid_q;
        rs_d       = rs_q;
        rt_d       = rt_q;
        op_d       = op_q;
        rd_d       = rd_q;

        case (state_q)
            EMPTY:   if (handshake) state_d = FULL;
            FULL:    if (issue) state_d = handshake ? FULL : EMPTY;
            default: state_d = EMPTY;
        endcase

        if (handshake) buf_d = instr_t'(bus.instr_i);

        // Set after clear so an issuing writer wins over a same-register writeback.
        pend_d = pend_q & ~wb_mask;
        if (issue && (buf_q.rd != '0)) pend_d[buf_q.rd] = 1'b1;
        pend_d[0] = 1'b0;

        if (issue) begin
            ex_valid_d = 1'b1;
            rs_d       = opnd_a;
            rt_d       = opnd_b;
            op_d       = buf_q.op;
            rd_d       = buf_q.rd;
        end else if (bus.ex_ready_i) begin
            ex_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            buf_q      <= '0;
            pend_q     <= '0;
            ex_valid_q <= 1'b0;
            rs_q       <= '0;
            rt_q       <= '0;
            op_q       <= OP_OR;
            rd_q       <= '0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            pend_q     <= pend_d;
            ex_valid_q <= ex_valid_d;
            rs_q       <= rs_d;
            rt_q       <= rt_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
        end
    end

    assign bus.instr_ready_o = (state_q == EMPTY) || issue;
    assign bus.ex_valid_o    = ex_valid_q;
    assign bus.rs_o          = rs_q;
    assign bus.rt_o          = rt_q;
    assign bus.op_o          = op_q;
    assign bus.rd_o          = rd_q;

endmodule

// File: doc/decode_issue.md
# decode_issue

Operand-fetch and issue stage directly upstream of the ALU. Accepts 32-bit instruction words over a valid/ready handshake and holds each one in a one-entry buffer. Reads the operands from an internal 8×32 register file, checks a per-register scoreboard for pending writes, then issues `{op, rs, rt, rd}` to the ALU stage through a registered valid/ready output. Results return through a writeback port that updates the register file and clears the scoreboard.

## Interface
- No parameters. Register count (8) and instruction field positions are fixed constants in `definitions`.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state.
- `instr_valid_i` in 1: upstream has an instruction.
- `instr_i` in 32: instruction word.
- `instr_ready_o` out 1: block accepts `instr_i` this cycle.
- `wb_en_i` in 1: writeback strobe.
- `wb_addr_i` in 3: writeback destination.
- `wb_data_i` in 32: writeback data.
- `ex_valid_o` out 1: issue register holds a valid instruction.
- `ex_ready_i` in 1: the ALU stage consumes the issue register this cycle.
- `rs_o` in/out: out, 32: operand A to ALU `rs_i`.
- `rt_o` out 32: operand B to ALU `rt_i`. This is the register value, or the zero-extended immediate when `use_imm` is set.
- `op_o` out `op_code`: to ALU `op_i`.
- `rd_o` out 3: destination register, carried to writeback.

## Operation
- Instruction fields:
  - `op` = `[31:30]`: OR=0, AND=1, ADD=2, SUB=3.
  - `rd` = `[29:27]`, `ra` = `[26:24]`, `rb` = `[23:21]`.
  - `use_imm` = `[20]`.
  - `imm` = `[15:0]`, zero-extended to 32 bits.
  - Bits `[19:16]` are ignored.
- Register file:
  - r0 always reads 0.
  - Writes to r0 are discarded.
  - Write occurs at the clock edge when `wb_en_i`=1.
- Scoreboard: 8 pending bits, with bit 0 always 0.
  - Set `pend[rd]` when an instruction issues with rd≠0.
  - Clear `pend[wb_addr_i]` when `wb_en_i`=1.
  - If set and clear target the same register in the same cycle, set wins.
- Effective pending: `pend[x]` AND NOT (`wb_en_i` AND `wb_addr_i`==x). A register being written back this cycle counts as not pending.
- Hazard: effective-pending on `ra`, on `rb` (only when `use_imm`=0), or on `rd` (WAW).
- Buffer FSM states:
  - **EMPTY**
    - `instr_ready_o`=1.
    - Handshake → FULL, capture `instr_i`.
  - **FULL**
    - `issue` = no hazard AND (`ex_valid_o`=0 OR `ex_ready_i`=1).
    - `instr_ready_o` = `issue`.
    - `issue` with a new handshake → FULL, capture the new word.
    - `issue` without a handshake → EMPTY.
    - Otherwise stay in FULL.
- `instr_ready_o` never depends combinationally on `instr_i` or `instr_valid_i`.
- On `issue`:
  - Issue register loads `op`, `rd`, and the operands.
  - Operands are read from the register file with bypass: if `wb_en_i`=1 and `wb_addr_i` equals a nonzero source address, `wb_data_i` is used.
  - `ex_valid_o` ← 1.
- Output drain:
  - `ex_ready_i`=1 with no `issue` → `ex_valid_o` ← 0.
  - Output contents hold while `ex_valid_o`=1 and `ex_ready_i`=0.
- Reset (any time, including mid-stall or mid-handshake):
  - State EMPTY, `ex_valid_o`=0.
  - `rs_o`, `rt_o`, `rd_o`, `op_o` = 0 (`op_o` = OR).
  - Registers = 0, scoreboard = 0.
  - `instr_ready_o` = 1 combinationally while in EMPTY.
  - An in-flight instruction is lost.

## Timing
- Accept at edge N → earliest `ex_valid_o`=1 after edge N+1.
- Sustained throughput: 1 instruction/cycle when there are no hazards and `ex_ready_i`=1.
- A dependent instruction stalls until the cycle in which its source's `wb_en_i` is asserted. It issues at that edge with bypassed data, so there is zero extra bubble beyond writeback.
- Writeback to a non-pending register is legal and updates the register file only.

## Structure
- `definitions` package:
  - Existing `op_code`.
  - New `instr_t` packed struct with the fields above.
  - `NUM_REGS`=8.
  - State enum `dec_state_e` {EMPTY, FULL}.
- Sub-module `regfile_8x32`:
  - Two combinational read ports, one synchronous write port.
  - r0 hardwired to zero.
  - Asynchronous reset clears all registers.
- Bypass, scoreboard, FSM and issue register live in `decode_issue`.

## Test plan
- Reset mid-FULL with `ex_valid_o`=1 → immediately `ex_valid_o`=0, outputs 0, `instr_ready_o`=1. Reading r1 afterwards returns 0.
- Writeback r1=5 and r2=3, then issue ADD rd=3 ra=1 rb=2 with `ex_ready_i`=1 → `rs_o`=5, `rt_o`=3, `op_o`=ADD, `rd_o`=3, one cycle after accept.
- Issue SUB rd=4 ra=0 with `use_imm`=1, imm=0xFFFF → `rs_o`=0, `rt_o`=0x0000FFFF. The `rb` field is ignored even when its register is pending.
- Issue ADD rd=1, then OR ra=1 → second instruction stalls with `instr_ready_o`=0. In the cycle that `wb_en_i`=1, `wb_addr_i`=1, `wb_data_i`=0xA5 is presented, it issues at that edge with `rs_o`=0xA5.
- Hold `ex_ready_i`=0 for 3 cycles with 2 instructions offered → output held stable, buffer FULL, second word waits. Then release → the two instructions issue on consecutive cycles in order.
- Instruction with rd=0 issues → scoreboard unchanged. A following instruction reading r0 gets 0 with no stall.
